// File: rtl/temporizador_nota_pkg.sv
// Shared definitions for the note timer and the melody controller:
// note-width, FSM encodings and the board clock frequency.
package temporizador_nota_pkg;

    localparam int NOTE_W   = 28;
    localparam int clk_FPGA = 50_000_000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_EXPIRE = 2'd2
    } estado_t;

    // A zero duration still times one cycle so the controller always sees a pulse.
    function automatic logic [NOTE_W-1:0] dur_load(input logic [NOTE_W-1:0] t);
        return (t == '0) ? NOTE_W'(1) : t;
    endfunction

endpackage

// File: rtl/temporizador_nota_divisor_tom.sv
// Square-wave tone divider: toggles Tone_out every Freq cycles while enabled,
// restarting silently whenever the requested half-period changes.
module divisor_tom
    import temporizador_nota_pkg::*;
(
    input  logic              Clk_in,
    input  logic              Rst_n,
    input  logic [NOTE_W-1:0] Freq,
    input  logic              enable,
    output logic              Tone_out
);

    logic [NOTE_W-1:0] freq_reg;
    logic [NOTE_W-1:0] tone_cnt_reg;
    logic [NOTE_W-1:0] tone_cnt_next;
    logic              tone_reg;
    logic              tone_next;

    always_comb begin
        tone_cnt_next = tone_cnt_reg;
        tone_next     = tone_reg;
        if ((Freq != freq_reg) || (Freq == '0) || !enable) begin
            tone_cnt_next = '0;
            tone_next     = 1'b0;
        end else if (tone_cnt_reg == (Freq - NOTE_W'(1))) begin
            tone_cnt_next = '0;
            tone_next     = ~tone_reg;
        end else begin
            tone_cnt_next = tone_cnt_reg + NOTE_W'(1);
        end
    end

    always_ff @(posedge Clk_in or negedge Rst_n) begin
        if (!Rst_n) begin
            freq_reg     <= '0;
            tone_cnt_reg <= '0;
            tone_reg     <= 1'b0;
        end else begin
            freq_reg     <= Freq;
            tone_cnt_reg <= tone_cnt_next;
            tone_reg     <= tone_next;
        end
    end

    assign Tone_out = tone_reg;

endmodule

// File: rtl/temporizador_nota.sv
// Note duration timer: times each note loaded by the melody controller,
// supports pause/stop, and drives the tone divider while a note is counting.
module temporizador_nota
    import temporizador_nota_pkg::*;
(
    input  logic              Clk_in,
    input  logic              Rst_n,
    input  logic              Disparo,
    input  logic [NOTE_W-1:0] Temp_in,
    input  logic [NOTE_W-1:0] Freq_in,
    input  logic              Play_in,
    input  logic              Stop_in,
    output logic              Duracao,
    output logic              Tone_out,
    output logic              Busy
);

    estado_t           state_reg;
    estado_t           state_next;
    logic [NOTE_W-1:0] dur_cnt_reg;
    logic [NOTE_W-1:0] dur_cnt_next;
    logic              duracao_reg;
    logic              load;
    logic              tone_en;

    assign load    = Disparo & Play_in & ~Stop_in;
    assign tone_en = (state_reg == ST_COUNT) & Play_in & ~Stop_in;

    always_comb begin
        state_next   = state_reg;
        dur_cnt_next = dur_cnt_reg;
        if (Stop_in) begin
            state_next   = ST_IDLE;
            dur_cnt_next = '0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_EXPIRE: begin
                    if (load) begin
                        state_next   = ST_COUNT;
                        dur_cnt_next = dur_load(Temp_in);
                    end
                end
                ST_COUNT: begin
                    // Counter never goes below zero; reaching 1 ends the note.
                    if (Play_in) begin
                        if (dur_cnt_reg <= NOTE_W'(1)) begin
                            state_next   = ST_EXPIRE;
                            dur_cnt_next = '0;
                        end else begin
                            dur_cnt_next = dur_cnt_reg - NOTE_W'(1);
                        end
                    end
                end
                default: begin
                    state_next   = ST_IDLE;
                    dur_cnt_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk_in or negedge Rst_n) begin
        if (!Rst_n) begin
            state_reg   <= ST_IDLE;
            dur_cnt_reg <= '0;
            duracao_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            dur_cnt_reg <= dur_cnt_next;
            duracao_reg <= (state_next == ST_COUNT);
        end
    end

    assign Duracao = duracao_reg;
    assign Busy    = (state_reg != ST_IDLE);

    divisor_tom u_divisor_tom (
        .Clk_in   (Clk_in),
        .Rst_n    (Rst_n),
        .Freq     (Freq_in),
        .enable   (tone_en),
        .Tone_out (Tone_out)
    );

endmodule
